// File: rtl/serial_word_tx.sv
//------------------------------------------------------------------------------
// serial_word_tx
//   Parallel-to-serial front end. Accepts WIDTH-bit words over a valid/ready
//   handshake, holds one word ahead of the shifter and emits each word MSB
//   first, one bit per clock, qualified by sout_valid.
//
//   Optional feature macro: SERIAL_WORD_TX_PARITY_EN
//     When defined, an even-parity bit follows every word's LSB and word_done
//     moves to that parity cycle.
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   asynchronous reset, active low
//   din         in   [WIDTH-1:0] parallel word
//   din_valid   in   din holds a word to transfer
//   din_ready   out  holding buffer can accept a word (combinational)
//   sout        out  serial bit, MSB first
//   sout_valid  out  sout carries a real bit this cycle
//   word_done   out  pulse during the final bit of each word
//
// Revision: 1.0 initial release
//------------------------------------------------------------------------------
`default_nettype none

module serial_word_tx #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             sout,
   output logic             sout_valid,
   output logic             word_done
);

   localparam int            CW       = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

`ifdef SERIAL_WORD_TX_PARITY_EN
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_PARITY = 2'd2
   } state_t;
`else
   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;
`endif

   state_t           state_q, state_d;
   logic [WIDTH-1:0] hold_q, hold_d;
   logic             hold_full_q, hold_full_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             accept;
   logic             reload;
`ifdef SERIAL_WORD_TX_PARITY_EN
   logic             par_q, par_d;
`endif

   // Ready is gated by rst so it reads 0 for the whole time reset is held.
   assign din_ready = rst & ~hold_full_q;
   assign accept    = din_valid & din_ready;

   always_comb begin
      state_d     = state_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      shreg_d     = shreg_q;
      cnt_d       = cnt_q;
      reload      = 1'b0;
`ifdef SERIAL_WORD_TX_PARITY_EN
      par_d       = par_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (hold_full_q) begin
               reload = 1'b1;
            end
         end
         ST_SHIFT: begin
            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
            if (cnt_q == '0) begin
               cnt_d = '0;
`ifdef SERIAL_WORD_TX_PARITY_EN
               state_d = ST_PARITY;
`else
               // Chain straight into the next word when one is waiting.
               if (hold_full_q) begin
                  reload = 1'b1;
               end else begin
                  state_d = ST_IDLE;
               end
`endif
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
`ifdef SERIAL_WORD_TX_PARITY_EN
         ST_PARITY: begin
            if (hold_full_q) begin
               reload = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
`endif
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (reload) begin
         shreg_d     = hold_q;
         cnt_d       = CNT_LOAD;
         hold_full_d = 1'b0;
         state_d     = ST_SHIFT;
`ifdef SERIAL_WORD_TX_PARITY_EN
         par_d       = ^hold_q;
`endif
      end

      // Cannot coincide with a reload: reload requires hold_full, which
      // holds din_ready low.
      if (accept) begin
         hold_d      = din;
         hold_full_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         shreg_q     <= '0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         shreg_q     <= shreg_d;
         cnt_q       <= cnt_d;
      end
   end

`ifdef SERIAL_WORD_TX_PARITY_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         par_q <= 1'b0;
      end else begin
         par_q <= par_d;
      end
   end

   assign sout       = (state_q == ST_SHIFT)  ? shreg_q[WIDTH-1] :
                       (state_q == ST_PARITY) ? par_q : 1'b0;
   assign sout_valid = (state_q != ST_IDLE);
   assign word_done  = (state_q == ST_PARITY);
`else
   assign sout       = (state_q == ST_SHIFT) & shreg_q[WIDTH-1];
   assign sout_valid = (state_q == ST_SHIFT);
   assign word_done  = (state_q == ST_SHIFT) & (cnt_q == '0);
`endif

endmodule

`default_nettype wire

// File: tb/tb_serial_word_tx.sv
//------------------------------------------------------------------------------
// tb_serial_word_tx
//   Directed bench for serial_word_tx, WIDTH=8 and WIDTH=4 instances.
//   Expected bit patterns are written out by hand for both builds
//   (SERIAL_WORD_TX_PARITY_EN defined or not).
//
// Revision: 1.0 initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_serial_word_tx;

`ifdef SERIAL_WORD_TX_PARITY_EN
   localparam int          P8      = 9;
   localparam logic [31:0] PAT_B0  = 32'h0000_0161;  // 10110000 1
   localparam logic [31:0] PAT_03  = 32'h0000_0006;  // 00000011 0
   localparam logic [31:0] PAT_B2B = 32'h0002_C217;  // 10110000 1 00001011 1
   localparam int          P4      = 5;
   localparam logic [31:0] PAT_4   = 32'h0000_0017;  // 1011 1
`else
   localparam int          P8      = 8;
   localparam logic [31:0] PAT_B0  = 32'h0000_00B0;
   localparam logic [31:0] PAT_03  = 32'h0000_0003;
   localparam logic [31:0] PAT_B2B = 32'h0000_B00B;
   localparam int          P4      = 4;
   localparam logic [31:0] PAT_4   = 32'h0000_000B;
`endif

   logic       clk;
   logic       rst;
   logic [7:0] din;
   logic       din_valid;
   logic       din_ready;
   logic       sout;
   logic       sout_valid;
   logic       word_done;

   logic [3:0] d4_din;
   logic       d4_din_valid;
   logic       d4_din_ready;
   logic       d4_sout;
   logic       d4_sout_valid;
   logic       d4_word_done;

   int n_checks;
   int n_errors;

   serial_word_tx #(.WIDTH(8)) u_dut8 (
      .clk        (clk),
      .rst        (rst),
      .din        (din),
      .din_valid  (din_valid),
      .din_ready  (din_ready),
      .sout       (sout),
      .sout_valid (sout_valid),
      .word_done  (word_done)
   );

   serial_word_tx #(.WIDTH(4)) u_dut4 (
      .clk        (clk),
      .rst        (rst),
      .din        (d4_din),
      .din_valid  (d4_din_valid),
      .din_ready  (d4_din_ready),
      .sout       (d4_sout),
      .sout_valid (d4_sout_valid),
      .word_done  (d4_word_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Checks n consecutive valid bits of pat (MSB first) on the 8-bit DUT.
   task automatic run_bits(input string tag, input logic [31:0] pat, input int n);
      for (int i = 0; i < n; i++) begin
         tick();
         check_eq({tag, " valid"}, 32'(sout_valid), 32'd1);
         check_eq({tag, " bit"},   32'(sout), 32'(pat[n-1-i]));
         check_eq({tag, " done"},  32'(word_done), 32'(i == n - 1));
      end
   endtask

   task automatic send_single(input string tag, input logic [7:0] data, input logic [31:0] pat);
      din       = data;
      din_valid = 1'b1;
      tick();                                   // accepting edge E
      din_valid = 1'b0;
      din       = 8'h00;                        // later din changes must not matter
      check_eq({tag, " ready after accept"}, 32'(din_ready), 32'd0);
      check_eq({tag, " no bit at E"}, 32'(sout_valid), 32'd0);
      run_bits(tag, pat, P8);
      tick();
      check_eq({tag, " idle valid"}, 32'(sout_valid), 32'd0);
      check_eq({tag, " idle sout"},  32'(sout), 32'd0);
      check_eq({tag, " idle ready"}, 32'(din_ready), 32'd1);
   endtask

   initial begin
      n_checks     = 0;
      n_errors     = 0;
      rst          = 1'b0;
      din          = 8'h00;
      din_valid    = 1'b0;
      d4_din       = 4'h0;
      d4_din_valid = 1'b0;

      // Reset state
      tick();
      tick();
      check_eq("rst ready",  32'(din_ready),  32'd0);
      check_eq("rst valid",  32'(sout_valid), 32'd0);
      check_eq("rst sout",   32'(sout),       32'd0);
      check_eq("rst done",   32'(word_done),  32'd0);
      check_eq("rst ready4", 32'(d4_din_ready), 32'd0);
      rst = 1'b1;
      tick();
      check_eq("post rst ready", 32'(din_ready), 32'd1);
      check_eq("post rst valid", 32'(sout_valid), 32'd0);

      // Single word
      send_single("B0", 8'hB0, PAT_B0);

      // Stall: nothing offered for 20 cycles
      for (int i = 0; i < 20; i++) begin
         tick();
         check_eq("stall valid", 32'(sout_valid), 32'd0);
         check_eq("stall ready", 32'(din_ready), 32'd1);
      end

      // Second single word (parity 0 in the parity build)
      send_single("03", 8'h03, PAT_03);

      // Back-to-back: B0 then 0B with din_valid held high
      din       = 8'hB0;
      din_valid = 1'b1;
      tick();                                   // E: B0 accepted
      din = 8'h0B;
      check_eq("b2b ready at E", 32'(din_ready), 32'd0);
      for (int k = 1; k <= 2 * P8; k++) begin
         tick();
         if (k == 2) din_valid = 1'b0;          // 0B accepted on edge E+2
         check_eq("b2b valid", 32'(sout_valid), 32'd1);
         check_eq("b2b bit",   32'(sout), 32'(PAT_B2B[2*P8-k]));
         check_eq("b2b done",  32'(word_done), 32'((k == P8) || (k == 2 * P8)));
         check_eq("b2b ready", 32'(din_ready), 32'((k == 1) || (k > P8)));
      end
      tick();
      check_eq("b2b end valid", 32'(sout_valid), 32'd0);

      // Reset mid-word: FF shifting, 55 held
      din       = 8'hFF;
      din_valid = 1'b1;
      tick();                                   // E: FF accepted
      din = 8'h55;
      tick();                                   // bit 1
      tick();                                   // bit 2, 55 accepted
      din_valid = 1'b0;
      check_eq("mid ready held", 32'(din_ready), 32'd0);
      tick();                                   // bit 3
      check_eq("mid bit3 valid", 32'(sout_valid), 32'd1);
      check_eq("mid bit3 sout",  32'(sout), 32'd1);
      #1 rst = 1'b0;
      #1;
      check_eq("mid rst valid", 32'(sout_valid), 32'd0);
      check_eq("mid rst sout",  32'(sout), 32'd0);
      check_eq("mid rst ready", 32'(din_ready), 32'd0);
      check_eq("mid rst done",  32'(word_done), 32'd0);
      tick();
      rst = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         check_eq("after rst valid", 32'(sout_valid), 32'd0);
         check_eq("after rst ready", 32'(din_ready), 32'd1);
      end

      // WIDTH=4 instance, din = 1011
      d4_din       = 4'b1011;
      d4_din_valid = 1'b1;
      tick();
      d4_din_valid = 1'b0;
      check_eq("w4 ready after accept", 32'(d4_din_ready), 32'd0);
      for (int i = 0; i < P4; i++) begin
         tick();
         check_eq("w4 valid", 32'(d4_sout_valid), 32'd1);
         check_eq("w4 bit",   32'(d4_sout), 32'(PAT_4[P4-1-i]));
         check_eq("w4 done",  32'(d4_word_done), 32'(i == P4 - 1));
      end
      tick();
      check_eq("w4 idle valid", 32'(d4_sout_valid), 32'd0);
      check_eq("w4 idle ready", 32'(d4_din_ready), 32'd1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
